fp_div_s: RTL
=============

Name: fp_div_s

Overview:
- Iterative IEEE-754 single-precision divider (DIV.S) for the Mini-MIPS FPU.
- Sits beside the combinational FP ALU in the execute stage. The ALU covers ADD.S/SUB.S/MUL.S/C.cond.S in one cycle; this block owns division, which is multi-cycle.
- Takes the same FP register operands, returns a 32-bit quotient to FP writeback, and raises busy so the pipeline stalls until done.

Parameters:
- None. Iteration count is fixed at 26 quotient bits; rounding is fixed to round-to-nearest-even.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a divide; sampled only in IDLE
- input1  input  32  dividend (fs), IEEE-754 single
- input2  input  32  divisor (ft), IEEE-754 single
- result  output  32  quotient; registered, held until the next accepted start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse, result valid
- div_by_zero  output  1  flag, valid with done, held with result
- invalid  output  1  flag (NaN operand, 0/0, inf/inf), valid with done
- overflow  output  1  flag, valid with done
- underflow  output  1  flag, valid with done

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - rst=1 at any edge: state=IDLE; result=0; busy=0; done=0; all flags=0.
  - Reset mid-operation aborts the divide with no done pulse.
- States: IDLE -> UNPACK -> (SPECIAL | DIVIDE) -> ROUND -> IDLE.
- IDLE:
  - start=1 at edge E latches input1/input2, clears flags, goes to UNPACK; busy=1 after E.
  - Start while busy is ignored. Operands are not re-sampled.
- UNPACK (1 cycle):
  - Split sign/exp/frac. Exponent 0 (zero or denormal) is treated as zero (flush-to-zero).
  - Sign = s1 XOR s2.
  - Special detection has priority order:
    1. Either NaN -> 0x7FC00000, invalid.
    2. 0/0 or inf/inf -> 0x7FC00000, invalid.
    3. Finite nonzero / 0 -> signed inf, div_by_zero.
    4. inf/finite -> signed inf.
    5. Finite/inf or 0/nonzero -> signed zero.
  - Any special case goes to SPECIAL; otherwise to DIVIDE.
- Normal path setup:
  - ma={1,f1}, mb={1,f2}; exp = e1 - e2 + 127, computed 10-bit signed.
  - If ma<mb: remainder starts at ma<<1 and exp -= 1. Otherwise remainder starts at ma.
- DIVIDE:
  - 26 cycles of restoring division, one quotient bit per cycle, MSB first: compare rem>=mb, subtract, shift left.
  - q[25] is always 1; q[24:2] fraction; q[1] guard; q[0] round. sticky = (final rem != 0).
- ROUND (1 cycle):
  - Round up if q[1] & (q[0] | sticky | q[2]).
  - Mantissa carry-out: frac=0, exp+1.
  - Apply limits after rounding:
    - exp>=255 -> signed inf, overflow.
    - exp<=0 -> signed zero, underflow.
  - Register result and flags; pulse done; busy=0; return to IDLE.
- SPECIAL (1 cycle): register special result and flags, pulse done, return to IDLE.
- Latency, with start accepted at edge E:
  - Normal: done high in the cycle after edge E+28 (1 UNPACK + 26 DIVIDE + 1 ROUND).
  - Special: done high in the cycle after edge E+2.
- Back-to-back: start may be asserted in the same cycle done is high. Since state is IDLE then, it is accepted.
- Sign of zero/inf results always follows s1 XOR s2; NaN output is always positive quiet NaN 0x7FC00000.

Test Plan:
- 0x40E00000 / 0x40000000 (7.0/2.0), start pulse -> done exactly 29 cycles after start edge; result 0x40600000; all flags 0; busy high for 28 cycles.
- 0x3F800000 / 0x40400000 (1.0/3.0) -> 0x3EAAAAAB (RNE rounds up); 0xBF800000 / 0x40400000 -> 0xBEAAAAAB.
- Specials, each done 3 cycles after start:
  - 0x3F800000/0x00000000 -> 0x7F800000, div_by_zero=1.
  - 0x80000000/0x00000000 -> 0x7FC00000, invalid=1.
  - 0x3F800000/0x7F800000 -> 0x00000000.
  - 0x7FC00001/0x3F800000 -> 0x7FC00000, invalid=1.
- Range limits:
  - 0x7F7FFFFF/0x3F000000 (FP_MAX/0.5) -> 0x7F800000, overflow=1.
  - 0x00800000/0x40000000 -> 0x00000000, underflow=1.
- Handshake:
  - Start re-asserted with different operands mid-divide -> ignored; original quotient returned.
  - Start asserted during done cycle -> second divide accepted; its done follows 29 cycles later.
- Reset: rst=1 at cycle 10 of a divide -> next cycle busy=0, done=0, result=0; no done pulse; a fresh divide afterwards completes correctly.

Source files
------------

// File: rtl/fp_div_s.sv
// Iterative IEEE-754 single-precision divider (DIV.S), RNE, flush-to-zero.
// start/input1/input2 in; result, busy, done and flags out (held until next op).
module fp_div_s (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_SPECIAL,
    S_DIVIDE,
    S_ROUND
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t             state;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic signed [9:0]  exp_q;
  logic [25:0]        rem_q;
  logic [24:0]        quo_q;
  logic [4:0]         cnt_q;

  logic        sgn;
  logic [7:0]  e1, e2;
  logic        z1, z2, i1, i2, n1, n2;
  logic [23:0] ma, mb;
  logic        lt;
  logic signed [9:0] exp_raw;

  assign sgn = a_q[31] ^ b_q[31];
  assign e1  = a_q[30:23];
  assign e2  = b_q[30:23];
  assign z1  = (e1 == 8'd0);
  assign z2  = (e2 == 8'd0);
  assign i1  = (e1 == 8'hFF) && (a_q[22:0] == 23'd0);
  assign i2  = (e2 == 8'hFF) && (b_q[22:0] == 23'd0);
  assign n1  = (e1 == 8'hFF) && (a_q[22:0] != 23'd0);
  assign n2  = (e2 == 8'hFF) && (b_q[22:0] != 23'd0);
  assign ma  = {1'b1, a_q[22:0]};
  assign mb  = {1'b1, b_q[22:0]};
  assign lt  = (ma < mb);
  assign exp_raw = $signed({2'b00, e1})
                 - $signed({2'b00, e2})
                 + 10'sd127;

  // Mutually exclusive special classes, built in priority order.
  logic c_inv, c_dz, c_inf, c_zero;
  assign c_inv  = n1 | n2 | (z1 & z2) | (i1 & i2);
  assign c_dz   = !c_inv & z2 & !i1;
  assign c_inf  = !c_inv & i1;
  assign c_zero = !c_inv & !i1 & !z2 & (i2 | z1);

  logic        sp_hit;
  logic [31:0] sp_res;
  logic        sp_inv;
  logic        sp_dz;

  always_comb begin
    sp_hit = 1'b1;
    sp_res = 32'd0;
    sp_inv = 1'b0;
    sp_dz  = 1'b0;
    unique case (1'b1)
      c_inv: begin
        sp_res = QNAN;
        sp_inv = 1'b1;
      end
      c_dz: begin
        sp_res = {sgn, 8'hFF, 23'd0};
        sp_dz  = 1'b1;
      end
      c_inf:  sp_res = {sgn, 8'hFF, 23'd0};
      c_zero: sp_res = {sgn, 31'd0};
      default: sp_hit = 1'b0;
    endcase
  end

  logic        ge;
  logic [25:0] nxt;
  assign ge  = (rem_q >= {2'b00, mb});
  assign nxt = ge ? (rem_q - {2'b00, mb}) : rem_q;

  // quo_q holds q[24:0]; q[25] is always 1 and shifts out.
  logic              rup;
  logic              carry;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;
  logic              ovf, unf;

  assign rup    = quo_q[1] & (quo_q[0] | (|rem_q) | quo_q[2]);
  assign carry  = rup & (&quo_q[24:2]);
  assign frac_r = quo_q[24:2] + {22'd0, rup};
  assign exp_r  = exp_q + (carry ? 10'sd1 : 10'sd0);
  assign ovf    = (exp_r >= 10'sd255);
  assign unf    = (exp_r <= 10'sd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      result      <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      exp_q       <= 10'sd0;
      rem_q       <= 26'd0;
      quo_q       <= 25'd0;
      cnt_q       <= 5'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q         <= input1;
            b_q         <= input2;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            busy        <= 1'b1;
            state       <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (sp_hit) begin
            state <= S_SPECIAL;
          end else begin
            rem_q <= lt ? {1'b0, ma, 1'b0}
                        : {2'b00, ma};
            exp_q <= lt ? exp_raw - 10'sd1
                        : exp_raw;
            quo_q <= 25'd0;
            cnt_q <= 5'd0;
            state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_q <= {nxt[24:0], 1'b0};
          quo_q <= {quo_q[23:0], ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd25) state <= S_ROUND;
        end
        S_ROUND: begin
          if (ovf) begin
            result   <= {sgn, 8'hFF, 23'd0};
            overflow <= 1'b1;
          end else if (unf) begin
            result    <= {sgn, 31'd0};
            underflow <= 1'b1;
          end else begin
            result <= {sgn, exp_r[7:0], frac_r};
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_SPECIAL: begin
          result      <= sp_res;
          invalid     <= sp_inv;
          div_by_zero <= sp_dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
